// File: rtl/seq_alu.sv
// seq_alu: execute-stage integer ALU with valid/ready handshake.
// Base RV32I ops (generalised to XLEN) complete in one cycle; RV M-extension
// multiply/divide runs on an iterative engine for exactly XLEN cycles.
module seq_alu #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      ALU_Control,
    input  logic [XLEN-1:0] operand_A,
    input  logic [XLEN-1:0] operand_B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_result,
    output logic            branch
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);
    localparam logic [SHW:0]    CNT_LAST = (SHW+1)'(XLEN - 1);
    localparam logic [SHW:0]    CNT_MAX  = (SHW+1)'(XLEN);

    state_t              r_state;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_result;
    logic                r_branch;
    logic [SHW:0]        r_cnt;
    logic [2*XLEN-1:0]   r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     r_opnd;    // multiplicand or divisor magnitude
    logic [2:0]          r_funct3;
    logic                r_neg;     // final result needs negation

    logic                w_accept;
    logic                w_is_m;
    logic [2:0]          w_f3;
    logic [SHW-1:0]      w_shamt;
    logic                w_lt;
    logic                w_ltu;
    logic                w_eq;
    logic [XLEN-1:0]     w_base_result;
    logic                w_base_branch;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_neg;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_special;
    logic                w_fast;
    logic [XLEN-1:0]     w_special_result;
    logic [XLEN-1:0]     w_fast_result;
    logic                w_fast_branch;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_shift;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_diff;
    logic [XLEN-1:0]     w_div_rem;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_iter_next;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_final_result;

    assign in_ready   = !reset && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = r_out_valid;
    assign ALU_result = r_result;
    assign branch     = r_branch;

    assign w_is_m  = ALU_Control[5];
    assign w_f3    = ALU_Control[2:0];
    assign w_shamt = operand_B[SHW-1:0];
    assign w_lt    = $signed(operand_A) < $signed(operand_B);
    assign w_ltu   = operand_A < operand_B;
    assign w_eq    = operand_A == operand_B;

    // Single-cycle base ALU: arithmetic/logic/shift, branch compare, jump passthrough
    always_comb begin
        w_base_result = ZERO;
        w_base_branch = 1'b0;
        case (ALU_Control[4:3])
            2'b00: begin
                case (w_f3)
                    3'b000:  w_base_result = operand_A + operand_B;
                    3'b001:  w_base_result = operand_A << w_shamt;
                    3'b010:  w_base_result = {{(XLEN-1){1'b0}}, w_lt};
                    3'b011:  w_base_result = {{(XLEN-1){1'b0}}, w_ltu};
                    3'b100:  w_base_result = operand_A ^ operand_B;
                    3'b101:  w_base_result = operand_A >> w_shamt;
                    3'b110:  w_base_result = operand_A | operand_B;
                    3'b111:  w_base_result = operand_A & operand_B;
                    default: w_base_result = ZERO;
                endcase
            end
            2'b01: begin
                case (w_f3)
                    3'b000:  w_base_result = operand_A - operand_B;
                    3'b001:  w_base_result = operand_A << w_shamt;
                    3'b101:  w_base_result = $unsigned($signed(operand_A) >>> w_shamt);
                    default: w_base_result = ZERO;
                endcase
            end
            2'b10: begin
                case (w_f3)
                    3'b000:  w_base_branch = w_eq;
                    3'b001:  w_base_branch = !w_eq;
                    3'b100:  w_base_branch = w_lt;
                    3'b101:  w_base_branch = !w_lt;
                    3'b110:  w_base_branch = w_ltu;
                    3'b111:  w_base_branch = !w_ltu;
                    default: w_base_branch = 1'b0;
                endcase
                w_base_result = {{(XLEN-1){1'b0}}, w_base_branch};
            end
            2'b11: begin
                w_base_result = {operand_A[XLEN-1:1], 1'b0};
            end
            default: begin
                w_base_result = ZERO;
                w_base_branch = 1'b0;
            end
        endcase
    end

    // Operand signedness and magnitudes for the iterative engine
    assign w_a_signed = w_f3[2] ? !w_f3[0] : (w_f3 != 3'b011);
    assign w_b_signed = w_f3[2] ? !w_f3[0] : !w_f3[1];
    assign w_sign_a   = w_a_signed && operand_A[XLEN-1];
    assign w_sign_b   = w_b_signed && operand_B[XLEN-1];
    assign w_mag_a    = w_sign_a ? (ZERO - operand_A) : operand_A;
    assign w_mag_b    = w_sign_b ? (ZERO - operand_B) : operand_B;
    // Remainder follows the dividend; quotient and product follow both signs
    assign w_neg      = (w_f3[2] && w_f3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);

    // Divide corner cases never enter the iterative engine
    assign w_div_zero = (operand_B == ZERO);
    assign w_div_ovf  = !w_f3[0] && (operand_A == MIN_NEG) && (operand_B == ALL_ONES);
    assign w_special  = w_is_m && w_f3[2] && (w_div_zero || w_div_ovf);
    assign w_fast     = !w_is_m || w_special;

    // Result for divide-by-zero and signed-overflow divides
    always_comb begin
        w_special_result = ZERO;
        if (w_div_zero) begin
            w_special_result = w_f3[1] ? operand_A : ALL_ONES;
        end else begin
            w_special_result = w_f3[1] ? ZERO : operand_A;
        end
    end

    assign w_fast_result = w_is_m ? w_special_result : w_base_result;
    assign w_fast_branch = w_is_m ? 1'b0 : w_base_branch;

    // One shift-add multiply step
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {1'b0, ZERO});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // One restoring-divide step
    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_opnd};
    assign w_div_diff  = w_div_shift[XLEN-1:0] - r_opnd;
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
    assign w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};

    assign w_iter_next = r_funct3[2] ? w_div_next : w_mul_next;
    assign w_prod_fix  = r_neg ? ({(2*XLEN){1'b0}} - w_iter_next) : w_iter_next;

    // Sign fix-up and result selection applied on the last iteration
    always_comb begin
        w_final_result = ZERO;
        if (r_funct3[2]) begin
            if (r_funct3[1]) begin
                w_final_result = r_neg ? (ZERO - w_iter_next[2*XLEN-1:XLEN]) : w_iter_next[2*XLEN-1:XLEN];
            end else begin
                w_final_result = r_neg ? (ZERO - w_iter_next[XLEN-1:0]) : w_iter_next[XLEN-1:0];
            end
        end else begin
            if (r_funct3 == 3'b000) begin
                w_final_result = w_prod_fix[XLEN-1:0];
            end else begin
                w_final_result = w_prod_fix[2*XLEN-1:XLEN];
            end
        end
    end

    // Control FSM, iterative engine state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= ZERO;
            r_branch    <= 1'b0;
            r_cnt       <= {(SHW+1){1'b0}};
            r_acc       <= {(2*XLEN){1'b0}};
            r_opnd      <= ZERO;
            r_funct3    <= 3'b000;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_fast) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_fast_result;
                            r_branch    <= w_fast_branch;
                        end else begin
                            r_state     <= S_BUSY;
                            r_out_valid <= 1'b0;
                            r_cnt       <= {(SHW+1){1'b0}};
                            r_acc       <= {ZERO, w_mag_a};
                            r_opnd      <= w_mag_b;
                            r_funct3    <= w_f3;
                            r_neg       <= w_neg;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state     <= r_state;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_iter_next;
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_final_result;
                        r_branch    <= 1'b0;
                    end else begin
                        r_state     <= S_BUSY;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
